// File: rtl/ul4_arbiter.sv
// ul4_arbiter: shares one ul4 between two requesters; response HOLD_CYCLES edges after accept,
// held until resp_ready, no new accept outside IDLE. Define UL4_ARB_RR_EN for round-robin, else fixed priority.
module ul4_arbiter #(
  parameter int WIDTH       = 4,
  parameter int SEL_W       = 2,
  parameter int HOLD_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [SEL_W-1:0] req0_s,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [SEL_W-1:0] req1_s,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic [WIDTH-1:0] ul4_a,
  output logic [WIDTH-1:0] ul4_b,
  output logic [SEL_W-1:0] ul4_s,
  input  logic [WIDTH-1:0] ul4_out,
  output logic             busy,
  output logic             grant_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q;
  logic       resp_vld_q;
  logic       win;
  logic       accept;
  logic       capture;

`ifdef UL4_ARB_RR_EN
  logic last_q;

  // On a tie the requester that did not win last time goes first.
  assign win = (req0_valid && req1_valid) ? ~last_q : req1_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= win;
    end
  end
`else
  assign win = ~req0_valid;
`endif

  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          req0_ready = ~win;
          req1_ready = win;
          accept     = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (cnt_q == HOLD_LAST) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (grant_id ? resp1_ready : resp0_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      resp_vld_q <= 1'b0;
      resp_data  <= '0;
      ul4_a      <= '0;
      ul4_b      <= '0;
      ul4_s      <= '0;
      grant_id   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ul4_a    <= win ? req1_a : req0_a;
        ul4_b    <= win ? req1_b : req0_b;
        ul4_s    <= win ? req1_s : req0_s;
        grant_id <= win;
        cnt_q    <= '0;
      end else if (state_q == ISSUE) begin
        cnt_q <= cnt_q + 4'd1;
      end
      if (capture) begin
        resp_data  <= ul4_out;
        resp_vld_q <= 1'b1;
      end else if (state_q == RESP && state_d == IDLE) begin
        resp_vld_q <= 1'b0;
      end
    end
  end

  assign resp0_valid = resp_vld_q & ~grant_id;
  assign resp1_valid = resp_vld_q & grant_id;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ul4_arbiter.sv
// Bench for ul4_arbiter: directed and random transactions on HOLD_CYCLES=1 and =3 instances with an XOR ul4 stub.
module tb_ul4_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       req0_valid, req1_valid, resp0_ready, resp1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_s, req1_s;

  logic       a_r0r, a_r1r, a_p0v, a_p1v, a_bz, a_gid;
  logic [3:0] a_rd, a_ua, a_ub, a_out;
  logic [1:0] a_us;
  logic       c_r0r, c_r1r, c_p0v, c_p1v, c_bz, c_gid;
  logic [3:0] c_rd, c_ua, c_ub, c_out;
  logic [1:0] c_us;

  assign a_out = a_ua ^ a_ub;
  assign c_out = c_ua ^ c_ub;

  ul4_arbiter #(.WIDTH(4), .SEL_W(2), .HOLD_CYCLES(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(a_r0r), .req0_a(req0_a), .req0_b(req0_b), .req0_s(req0_s),
    .req1_valid(req1_valid), .req1_ready(a_r1r), .req1_a(req1_a), .req1_b(req1_b), .req1_s(req1_s),
    .resp0_valid(a_p0v), .resp0_ready(resp0_ready), .resp1_valid(a_p1v), .resp1_ready(resp1_ready),
    .resp_data(a_rd), .ul4_a(a_ua), .ul4_b(a_ub), .ul4_s(a_us), .ul4_out(a_out),
    .busy(a_bz), .grant_id(a_gid)
  );

  ul4_arbiter #(.WIDTH(4), .SEL_W(2), .HOLD_CYCLES(3)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(c_r0r), .req0_a(req0_a), .req0_b(req0_b), .req0_s(req0_s),
    .req1_valid(req1_valid), .req1_ready(c_r1r), .req1_a(req1_a), .req1_b(req1_b), .req1_s(req1_s),
    .resp0_valid(c_p0v), .resp0_ready(resp0_ready), .resp1_valid(c_p1v), .resp1_ready(resp1_ready),
    .resp_data(c_rd), .ul4_a(c_ua), .ul4_b(c_ub), .ul4_s(c_us), .ul4_out(c_out),
    .busy(c_bz), .grant_id(c_gid)
  );

  bit         sel3;
  int         hold;
  logic       o_r0r, o_r1r, o_p0v, o_p1v, o_bz, o_gid;
  logic [3:0] o_rd, o_ua, o_ub;
  logic [1:0] o_us;

  always_comb begin
    o_r0r = sel3 ? c_r0r : a_r0r;
    o_r1r = sel3 ? c_r1r : a_r1r;
    o_p0v = sel3 ? c_p0v : a_p0v;
    o_p1v = sel3 ? c_p1v : a_p1v;
    o_bz  = sel3 ? c_bz  : a_bz;
    o_gid = sel3 ? c_gid : a_gid;
    o_rd  = sel3 ? c_rd  : a_rd;
    o_ua  = sel3 ? c_ua  : a_ua;
    o_ub  = sel3 ? c_ub  : a_ub;
    o_us  = sel3 ? c_us  : a_us;
  end

  int checks = 0;
  int errors = 0;
  bit last_m;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Who should win given which requesters bid and who won last.
  function automatic bit win_m(input bit v0, input bit v1);
`ifdef UL4_ARB_RR_EN
    if (v0 && v1) return ~last_m;
    return v1;
`else
    return ~v0;
`endif
  endfunction

  // Starts at a negedge in IDLE; ends at the negedge after the response handshake.
  task automatic txn(input bit v0, input bit v1, input logic [3:0] a0, input logic [3:0] b0,
                     input logic [3:0] a1, input logic [3:0] b1, input logic [1:0] s0,
                     input logic [1:0] s1, input int bp);
    bit         w;
    logic [3:0] ea, eb, er;
    logic [1:0] es;
    int         lat;
    w  = win_m(v0, v1);
    ea = w ? a1 : a0;
    eb = w ? b1 : b0;
    es = w ? s1 : s0;
    er = ea ^ eb;
    req0_valid = v0; req1_valid = v1;
    req0_a = a0; req0_b = b0; req0_s = s0;
    req1_a = a1; req1_b = b1; req1_s = s1;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    #1;
    chk("idle_busy", o_bz, 0);
    chk("idle_rdy0", o_r0r, v0 && !w);
    chk("idle_rdy1", o_r1r, w);
    @(negedge clk);
    last_m = w;
    chk("grant_id", o_gid, w);
    chk("ul4_a", o_ua, ea);
    chk("ul4_b", o_ub, eb);
    chk("ul4_s", o_us, es);
    chk("issue_busy", o_bz, 1);
    chk("issue_rdy0", o_r0r, 0);
    chk("issue_rdy1", o_r1r, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = ~a0; req0_b = ~b0; req1_a = ~a1; req1_b = ~b1;
    lat = 0;
    while (!(w ? o_p1v : o_p0v) && lat < 40) begin
      @(negedge clk);
      lat++;
      chk("ul4_a_hold", o_ua, ea);
    end
    chk("latency", lat, hold);
    chk("resp_data", o_rd, er);
    chk("other_resp_vld", w ? o_p0v : o_p1v, 0);
    chk("resp_busy", o_bz, 1);
    for (int i = 0; i < bp; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      if (w) resp0_ready = 1'b1; else resp1_ready = 1'b1;
      #1;
      chk("bp_rdy0", o_r0r, 0);
      chk("bp_rdy1", o_r1r, 0);
      @(negedge clk);
      chk("bp_vld", w ? o_p1v : o_p0v, 1);
      chk("bp_data", o_rd, er);
      chk("bp_ul4_a", o_ua, ea);
    end
    resp0_ready = ~w; resp1_ready = w;
    @(negedge clk);
    chk("done_vld", w ? o_p1v : o_p0v, 0);
    chk("done_busy", o_bz, 0);
    resp0_ready = 1'b0; resp1_ready = 1'b0;
  endtask

  task automatic rand_txn(input int bp_max);
    bit v0, v1;
    v0 = 1'($urandom_range(0, 1));
    v1 = 1'($urandom_range(0, 1));
    if (!v0 && !v1) v0 = 1'b1;
    txn(v0, v1, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
        2'($urandom), 2'($urandom), $urandom_range(0, bp_max));
  endtask

  task automatic full_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    last_m = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    sel3 = 1'b0; hold = 1; last_m = 1'b1;
    reset_n = 1'b0;
    req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
    req0_a = 0; req0_b = 0; req0_s = 0; req1_a = 0; req1_b = 0; req1_s = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", o_bz, 0);
    chk("rst_gid", o_gid, 0);
    chk("rst_ua", o_ua, 0);
    chk("rst_rd", o_rd, 0);
    chk("rst_p0v", o_p0v, 0);
    chk("rst_p1v", o_p1v, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Contention: both valid continuously.
    for (int i = 0; i < 4; i++) txn(1, 1, 4'hF, 4'h4, 4'h9, 4'h4, 2'd0, 2'd0, 0);
    // Single request.
    txn(1, 0, 4'b0110, 4'b0100, 4'h0, 4'h0, 2'b01, 2'b00, 0);
    // Response backpressure on requester 1, followed by an immediate req0 accept.
    txn(0, 1, 4'h0, 4'h0, 4'hF, 4'hF, 2'd0, 2'd3, 5);
    txn(1, 0, 4'h3, 4'hA, 4'h0, 4'h0, 2'd2, 2'd0, 0);
    for (int i = 0; i < 40; i++) rand_txn(3);

    // Asynchronous reset in the middle of ISSUE.
    req0_valid = 1'b1; req0_a = 4'h5; req0_b = 4'h3; req0_s = 2'd1;
    @(negedge clk);
    req0_valid = 1'b0;
    chk("pre_rst_busy", o_bz, 1);
    reset_n = 1'b0;
    #1;
    chk("arst_busy", o_bz, 0);
    chk("arst_ua", o_ua, 0);
    chk("arst_ub", o_ub, 0);
    chk("arst_us", o_us, 0);
    chk("arst_gid", o_gid, 0);
    chk("arst_p0v", o_p0v, 0);
    #1;
    reset_n = 1'b1;
    last_m = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_p0v", o_p0v, 0);
      chk("abort_busy", o_bz, 0);
    end
    txn(1, 1, 4'h1, 4'h2, 4'h4, 4'h8, 2'd0, 2'd1, 0);
    chk("post_rst_tie_gid", o_gid, 0);

    // HOLD_CYCLES=3 instance.
    sel3 = 1'b1; hold = 3;
    full_reset();
    txn(0, 1, 4'h0, 4'h0, 4'b1001, 4'b0100, 2'd0, 2'b10, 1);
    for (int i = 0; i < 6; i++) rand_txn(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
